// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter requester: per-channel state encoding,
// channel count, retry limit and a wait-timeout helper.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } chan_state_t;

  localparam int NUM_CH      = 3;
  localparam int RETRY_LIMIT = 8;
  localparam int RETRY_W     = 4;
  localparam int WAIT_W      = 4;

  // True when the cycle now ending in REQ is the last one allowed before retry.
  function automatic logic wait_expired(input logic [WAIT_W-1:0] cnt,
                                        input int                limit);
    return (int'(cnt) + 1) == limit;
  endfunction

endpackage

// File: rtl/arb_req_chan.sv
// One requester channel: pending-job counter, IDLE/REQ/GAP request FSM,
// wait counter and sticky flags. ARB_REQ_RETRY_LIMIT_EN adds a retry limit.
module arb_req_chan
  import arb_pkg::*;
#(
  parameter int PEND_W   = 3,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              job,
  input  logic              gnt,
  output logic              r,
  output logic [PEND_W-1:0] pend,
  output logic              ovf,
  output logic              err
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  chan_state_t       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              in_req;
  logic              take;
  logic              timeout;
  logic              discard;
  logic              dec;
  logic              drop;
  logic [PEND_W-1:0] pend_nxt;

  assign in_req  = (state == ST_REQ);
  assign take    = in_req & gnt;
  assign timeout = in_req & ~gnt & wait_expired(wait_cnt, WAIT_CYC);

`ifdef ARB_REQ_RETRY_LIMIT_EN
  logic [RETRY_W-1:0] retry_cnt;

  // The timeout that would make the count reach the limit discards the head job.
  assign discard = timeout && (retry_cnt == RETRY_W'(RETRY_LIMIT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retry_cnt <= '0;
    end else if (take || discard) begin
      retry_cnt <= '0;
    end else if (timeout) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
`else
  assign discard = 1'b0;
`endif

  assign dec = take | discard;

  // Enqueue and dequeue on the same edge cancel; a full counter drops the job.
  always_comb begin
    pend_nxt = pend;
    drop     = 1'b0;
    if (job && !dec) begin
      if (pend == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pend_nxt = pend + 1'b1;
      end
    end else if (!job && dec) begin
      pend_nxt = pend - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      r        <= 1'b0;
      wait_cnt <= '0;
      pend     <= '0;
      ovf      <= 1'b0;
      err      <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (drop) begin
        ovf <= 1'b1;
      end
      if (gnt && !in_req) begin
        err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (pend != '0) begin
            state    <= ST_REQ;
            r        <= 1'b1;
            wait_cnt <= '0;
          end
        end
        ST_REQ: begin
          // The arbiter only sees rising edges, so every exit passes through GAP.
          if (take || timeout) begin
            state <= ST_GAP;
            r     <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (pend != '0) begin
            state    <= ST_REQ;
            r        <= 1'b1;
            wait_cnt <= '0;
          end else begin
            state <= ST_IDLE;
            r     <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/arb_requester.sv
// Three independent request channels feeding a fixed-priority arbiter.
// Optional retry limit per channel via ARB_REQ_RETRY_LIMIT_EN.
module arb_requester
  import arb_pkg::*;
#(
  parameter int PEND_W   = 3,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              job1,
  input  logic              job2,
  input  logic              job3,
  input  logic              a1,
  input  logic              a2,
  input  logic              a3,
  output logic              r1,
  output logic              r2,
  output logic              r3,
  output logic [PEND_W-1:0] pend1,
  output logic [PEND_W-1:0] pend2,
  output logic [PEND_W-1:0] pend3,
  output logic [2:0]        ovf,
  output logic [2:0]        err
);

  logic [NUM_CH-1:0] job_v;
  logic [NUM_CH-1:0] gnt_v;
  logic [NUM_CH-1:0] req_v;
  logic [PEND_W-1:0] pend_v [NUM_CH];

  assign job_v = {job3, job2, job1};
  assign gnt_v = {a3, a2, a1};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    arb_req_chan #(
      .PEND_W   (PEND_W),
      .WAIT_CYC (WAIT_CYC)
    ) u_chan (
      .clk  (clk),
      .rstn (rstn),
      .job  (job_v[i]),
      .gnt  (gnt_v[i]),
      .r    (req_v[i]),
      .pend (pend_v[i]),
      .ovf  (ovf[i]),
      .err  (err[i])
    );
  end

  assign r1    = req_v[0];
  assign r2    = req_v[1];
  assign r3    = req_v[2];
  assign pend1 = pend_v[0];
  assign pend2 = pend_v[1];
  assign pend3 = pend_v[2];

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester with a scoreboard queue of expected snapshots.
module tb_arb_requester;

  localparam int PEND_W   = 3;
  localparam int WAIT_CYC = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic              job1, job2, job3;
  logic              a1, a2, a3;
  logic              r1, r2, r3;
  logic [PEND_W-1:0] pend1, pend2, pend3;
  logic [2:0]        ovf, err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    logic [2:0] r;
    logic [2:0] p1;
    logic [2:0] p2;
    logic [2:0] p3;
    logic [2:0] ovf;
    logic [2:0] err;
  } exp_t;

  exp_t sb[$];

  arb_requester #(
    .PEND_W   (PEND_W),
    .WAIT_CYC (WAIT_CYC)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .job1  (job1),
    .job2  (job2),
    .job3  (job3),
    .a1    (a1),
    .a2    (a2),
    .a3    (a3),
    .r1    (r1),
    .r2    (r2),
    .r3    (r3),
    .pend1 (pend1),
    .pend2 (pend2),
    .pend3 (pend3),
    .ovf   (ovf),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of pulses, queue the expected post-edge state, then compare.
  task automatic step(input string tag, input logic [2:0] job, input logic [2:0] gnt,
                      input logic [2:0] er, input logic [2:0] ep1, input logic [2:0] ep2,
                      input logic [2:0] ep3, input logic [2:0] eovf, input logic [2:0] eerr);
    exp_t e;
    e.tag = tag; e.r = er; e.p1 = ep1; e.p2 = ep2; e.p3 = ep3; e.ovf = eovf; e.err = eerr;
    {job3, job2, job1} = job;
    {a3, a2, a1}       = gnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    {job3, job2, job1} = 3'b000;
    {a3, a2, a1}       = 3'b000;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_r"},    {29'd0, r3, r2, r1}, {29'd0, e.r});
      chk({e.tag, "_p1"},   {29'd0, pend1},      {29'd0, e.p1});
      chk({e.tag, "_p2"},   {29'd0, pend2},      {29'd0, e.p2});
      chk({e.tag, "_p3"},   {29'd0, pend3},      {29'd0, e.p3});
      chk({e.tag, "_ovf"},  {29'd0, ovf},        {29'd0, e.ovf});
      chk({e.tag, "_err"},  {29'd0, err},        {29'd0, e.err});
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_r"},   {29'd0, r3, r2, r1}, 32'd0);
    chk({tag, "_p1"},  {29'd0, pend1},      32'd0);
    chk({tag, "_p2"},  {29'd0, pend2},      32'd0);
    chk({tag, "_p3"},  {29'd0, pend3},      32'd0);
    chk({tag, "_ovf"}, {29'd0, ovf},        32'd0);
    chk({tag, "_err"}, {29'd0, err},        32'd0);
  endtask

  initial begin
    logic [2:0] er1;
    logic [2:0] ep1;
    rstn = 1'b0;
    {job3, job2, job1} = 3'b000;
    {a3, a2, a1}       = 3'b000;
    #12;
    chk_cleared("rst");
    rstn = 1'b1;

    // Single job granted on first attempt.
    step("t1_job",  3'b001, 3'b000, 3'b000, 3'd1, 3'd0, 3'd0, 3'b000, 3'b000);
    step("t1_req",  3'b000, 3'b000, 3'b001, 3'd1, 3'd0, 3'd0, 3'b000, 3'b000);
    step("t1_gnt",  3'b000, 3'b001, 3'b000, 3'd0, 3'd0, 3'd0, 3'b000, 3'b000);
    step("t1_gap",  3'b000, 3'b000, 3'b000, 3'd0, 3'd0, 3'd0, 3'b000, 3'b000);
    step("t1_idle", 3'b000, 3'b000, 3'b000, 3'd0, 3'd0, 3'd0, 3'b000, 3'b000);

    // Two channels contend; channel 1 wins, channel 2 times out and retries.
    step("t2_jobs",  3'b011, 3'b000, 3'b000, 3'd1, 3'd1, 3'd0, 3'b000, 3'b000);
    step("t2_req",   3'b000, 3'b000, 3'b011, 3'd1, 3'd1, 3'd0, 3'b000, 3'b000);
    step("t2_g1",    3'b000, 3'b001, 3'b010, 3'd0, 3'd1, 3'd0, 3'b000, 3'b000);
    step("t2_tmo",   3'b000, 3'b000, 3'b000, 3'd0, 3'd1, 3'd0, 3'b000, 3'b000);
    step("t2_rereq", 3'b000, 3'b000, 3'b010, 3'd0, 3'd1, 3'd0, 3'b000, 3'b000);
    step("t2_g2",    3'b000, 3'b010, 3'b000, 3'd0, 3'd0, 3'd0, 3'b000, 3'b000);
    step("t2_idle",  3'b000, 3'b000, 3'b000, 3'd0, 3'd0, 3'd0, 3'b000, 3'b000);

    // Spurious grant to an idle channel.
    step("t3_spur", 3'b000, 3'b010, 3'b000, 3'd0, 3'd0, 3'd0, 3'b000, 3'b010);

    // Eight back-to-back jobs on channel 3 with no grants: saturate and overflow.
    step("t4_j1",  3'b100, 3'b000, 3'b000, 3'd0, 3'd0, 3'd1, 3'b000, 3'b010);
    step("t4_j2",  3'b100, 3'b000, 3'b100, 3'd0, 3'd0, 3'd2, 3'b000, 3'b010);
    step("t4_j3",  3'b100, 3'b000, 3'b100, 3'd0, 3'd0, 3'd3, 3'b000, 3'b010);
    step("t4_j4",  3'b100, 3'b000, 3'b000, 3'd0, 3'd0, 3'd4, 3'b000, 3'b010);
    step("t4_j5",  3'b100, 3'b000, 3'b100, 3'd0, 3'd0, 3'd5, 3'b000, 3'b010);
    step("t4_j6",  3'b100, 3'b000, 3'b100, 3'd0, 3'd0, 3'd6, 3'b000, 3'b010);
    step("t4_j7",  3'b100, 3'b000, 3'b000, 3'd0, 3'd0, 3'd7, 3'b000, 3'b010);
    step("t4_j8",  3'b100, 3'b000, 3'b100, 3'd0, 3'd0, 3'd7, 3'b100, 3'b010);
    step("t4_w1",  3'b000, 3'b000, 3'b100, 3'd0, 3'd0, 3'd7, 3'b100, 3'b010);
    step("t4_gap", 3'b000, 3'b000, 3'b000, 3'd0, 3'd0, 3'd7, 3'b100, 3'b010);
    step("t4_req", 3'b000, 3'b000, 3'b100, 3'd0, 3'd0, 3'd7, 3'b100, 3'b010);

    // Build r1=1, pend1=3 while channel 3 keeps cycling, then reset mid-request.
    step("t5_j1", 3'b001, 3'b000, 3'b100, 3'd1, 3'd0, 3'd7, 3'b100, 3'b010);
    step("t5_j2", 3'b001, 3'b000, 3'b001, 3'd2, 3'd0, 3'd7, 3'b100, 3'b010);
    step("t5_j3", 3'b001, 3'b000, 3'b101, 3'd3, 3'd0, 3'd7, 3'b100, 3'b010);
    chk("t5_pre_r1", {31'd0, r1}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk_cleared("t5_async");
    @(posedge clk);
    #1;
    chk_cleared("t5_hold");
    rstn = 1'b1;
    step("t5_nogrant", 3'b000, 3'b001, 3'b000, 3'd0, 3'd0, 3'd0, 3'b000, 3'b001);

    // Job and grant on the same edge leave pend unchanged.
    step("t6_job",    3'b001, 3'b000, 3'b000, 3'd1, 3'd0, 3'd0, 3'b000, 3'b001);
    step("t6_req",    3'b000, 3'b000, 3'b001, 3'd1, 3'd0, 3'd0, 3'b000, 3'b001);
    step("t6_jobgnt", 3'b001, 3'b001, 3'b000, 3'd1, 3'd0, 3'd0, 3'b000, 3'b001);
    step("t6_rereq",  3'b000, 3'b000, 3'b001, 3'd1, 3'd0, 3'd0, 3'b000, 3'b001);
    step("t6_gnt",    3'b000, 3'b001, 3'b000, 3'd0, 3'd0, 3'd0, 3'b000, 3'b001);
    step("t6_idle",   3'b000, 3'b000, 3'b000, 3'd0, 3'd0, 3'd0, 3'b000, 3'b001);

    // One job, never granted: unlimited retries, or discard after 8 timeouts.
    #2;
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    step("t7_job", 3'b001, 3'b000, 3'b000, 3'd1, 3'd0, 3'd0, 3'b000, 3'b000);
    for (int k = 1; k <= 27; k++) begin
`ifdef ARB_REQ_RETRY_LIMIT_EN
      er1 = ((k % 3) != 0 && k < 24) ? 3'b001 : 3'b000;
      ep1 = (k < 24) ? 3'd1 : 3'd0;
`else
      er1 = ((k % 3) != 0) ? 3'b001 : 3'b000;
      ep1 = 3'd1;
`endif
      step($sformatf("t7_c%0d", k), 3'b000, 3'b000, er1, ep1, 3'd0, 3'd0, 3'b000, 3'b000);
    end

    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
